// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// master: datapath side (drives hazard inputs, receives enables/status).
// slave: controller side (reads hazard inputs, drives enables/status).
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;
   logic             ifid_uses_rt;
   logic             idex_mem_read;
   logic [4:0]       idex_rt;
   logic             branch_taken;
   logic             exmem_mem_req;
   logic             dmem_ready;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             pipe_en;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ifid_rs, ifid_rt, ifid_uses_rt,
      output idex_mem_read, idex_rt, branch_taken,
      output exmem_mem_req, dmem_ready,
      input  pc_write, ifid_write, ifid_flush,
      input  idex_bubble, pipe_en, mem_error,
      input  stall_cycles, flush_count
   );

   modport slave (
      input  ifid_rs, ifid_rt, ifid_uses_rt,
      input  idex_mem_read, idex_rt, branch_taken,
      input  exmem_mem_req, dmem_ready,
      output pc_write, ifid_write, ifid_flush,
      output idex_bubble, pipe_en, mem_error,
      output stall_cycles, flush_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: load-use bubbles, ID branch flushes, dmem waits.
// Ports: clk, rst (sync, active-high), hz (slave side of the hazard bundle).
module pipe_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN,
      MEM_WAIT,
      ERROR
   } state_t;

   state_t           state;
   logic [WC_W-1:0]  wcnt;
   logic             err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic lu;
   logic ms;
   logic hold;
   logic pc_w;
   logic ifid_w;
   logic flush;
   logic bubble;
   logic en;

   always_comb begin
      lu = hz.idex_mem_read & (hz.idex_rt != 5'd0) &
           ((hz.idex_rt == hz.ifid_rs) |
            (hz.ifid_uses_rt & (hz.idex_rt == hz.ifid_rt)));
      case (state)
         RUN:      ms = hz.exmem_mem_req & ~hz.dmem_ready;
         MEM_WAIT: ms = ~hz.dmem_ready;
         default:  ms = 1'b0;
      endcase
      // Reset, error and memory wait all freeze every stage.
      hold = rst | (state == ERROR) | ms;
   end

   always_comb begin
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      flush  = 1'b0;
      bubble = 1'b0;
      en     = 1'b0;
      priority case (1'b1)
         hold: ;
         // A branch seen during a bubble is dropped; ID re-resolves it.
         lu: begin
            bubble = 1'b1;
            en     = 1'b1;
         end
         default: begin
            pc_w   = 1'b1;
            ifid_w = 1'b1;
            en     = 1'b1;
            flush  = hz.branch_taken;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wcnt      <= '0;
         err       <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_w && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && !(&flush_cnt))
            flush_cnt <= flush_cnt + 1'b1;
         case (state)
            RUN: begin
               if (ms) begin
                  state <= MEM_WAIT;
                  wcnt  <= WC_W'(1);
               end
            end
            MEM_WAIT: begin
               if (hz.dmem_ready) begin
                  state <= RUN;
                  wcnt  <= '0;
               end else if (wcnt == WC_MAX) begin
                  state <= ERROR;
                  err   <= 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign hz.pc_write     = pc_w;
   assign hz.ifid_write   = ifid_w;
   assign hz.ifid_flush   = flush;
   assign hz.idex_bubble  = bubble;
   assign hz.pipe_en      = en;
   assign hz.mem_error    = err;
   assign hz.stall_cycles = stall_cnt;
   assign hz.flush_count  = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (CNT_W=3, MEM_TIMEOUT=4).
// Ports: none; drives the hazard bundle, checks enables, status, counters.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 3;
   localparam int TMO   = 4;
   localparam int CMAX  = 7;

   // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_en}
   localparam logic [4:0] NORM = 5'b11001;
   localparam logic [4:0] BR   = 5'b11101;
   localparam logic [4:0] LU   = 5'b00011;
   localparam logic [4:0] FRZ  = 5'b00000;

   typedef struct {
      logic [4:0] ctl;
      logic       err;
      int         stall;
      int         flush;
      bit         full;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(
      .CNT_W(CNT_W),
      .MEM_TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz(hz.slave)
   );

   exp_t sbq[$];
   exp_t cur;
   int   total = 0;
   int   bad   = 0;
   int   m_stall = 0;
   int   m_flush = 0;
   logic m_err = 1'b0;
   bit   init_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic step(input logic r, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] xrt,
                       input logic br, input logic req, input logic rdy,
                       input logic [4:0] ctl);
      exp_t e;
      @(posedge clk);
      #1;
      rst              = r;
      hz.ifid_rs       = rs;
      hz.ifid_rt       = rt;
      hz.ifid_uses_rt  = urt;
      hz.idex_mem_read = mr;
      hz.idex_rt       = xrt;
      hz.branch_taken  = br;
      hz.exmem_mem_req = req;
      hz.dmem_ready    = rdy;
      e.ctl   = ctl;
      e.err   = m_err;
      e.stall = m_stall;
      e.flush = m_flush;
      e.full  = init_done;
      sbq.push_back(e);
      if (r) begin
         m_stall   = 0;
         m_flush   = 0;
         m_err     = 1'b0;
         init_done = 1'b1;
      end else begin
         if (!ctl[4] && m_stall < CMAX) m_stall++;
         if (ctl[2] && m_flush < CMAX) m_flush++;
      end
   endtask

   task automatic nop();
      step(0, 5'd1, 5'd2, 1'b1, 0, 5'd0, 0, 0, 0, NORM);
   endtask

   task automatic do_rst();
      step(1, 5'd0, 5'd0, 1'b0, 0, 5'd0, 0, 0, 0, FRZ);
   endtask

   task automatic mwait(input logic rdy, input logic [4:0] ctl);
      step(0, 5'd1, 5'd2, 1'b0, 0, 5'd0, 0, 1, rdy, ctl);
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         cur = sbq.pop_front();
         chk("ctl", {27'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush,
                     hz.idex_bubble, hz.pipe_en}, {27'd0, cur.ctl});
         if (cur.full) begin
            chk("mem_error", {31'd0, hz.mem_error}, {31'd0, cur.err});
            chk("stall_cycles", {29'd0, hz.stall_cycles}, cur.stall);
            chk("flush_count", {29'd0, hz.flush_count}, cur.flush);
         end
      end
   end

   initial begin
      do_rst();
      do_rst();
      nop();
      // load-use on rs, then stall count visible
      step(0, 5'd8, 5'd3, 1'b0, 1, 5'd8, 0, 0, 0, LU);
      nop();
      // rt = 0 never hazards
      step(0, 5'd0, 5'd3, 1'b0, 1, 5'd0, 0, 0, 0, NORM);
      // load-use on rt only when rt is a source
      step(0, 5'd4, 5'd9, 1'b1, 1, 5'd9, 0, 0, 0, LU);
      step(0, 5'd4, 5'd9, 1'b0, 1, 5'd9, 0, 0, 0, NORM);
      // branch suppressed by load-use, then taken
      step(0, 5'd8, 5'd3, 1'b0, 1, 5'd8, 1, 0, 0, LU);
      step(0, 5'd8, 5'd3, 1'b0, 0, 5'd8, 1, 0, 0, BR);
      nop();
      // zero-wait access
      mwait(1'b1, NORM);
      nop();
      // priority ms > lu > branch, then 3-cycle wait
      do_rst();
      step(0, 5'd8, 5'd3, 1'b0, 1, 5'd8, 1, 1, 0, FRZ);
      mwait(1'b0, FRZ);
      mwait(1'b0, FRZ);
      mwait(1'b1, NORM);
      nop();
      // ready cycle with load-use takes the bubble
      mwait(1'b0, FRZ);
      step(0, 5'd8, 5'd3, 1'b0, 1, 5'd8, 0, 1, 1, LU);
      nop();
      // timeout: TMO+1 frozen cycles then sticky error
      do_rst();
      for (int i = 0; i < TMO + 1; i++) mwait(1'b0, FRZ);
      m_err = 1'b1;
      mwait(1'b1, FRZ);
      step(0, 5'd8, 5'd3, 1'b0, 0, 5'd8, 1, 0, 1, FRZ);
      nop_err();
      do_rst();
      nop();
      // reset in the middle of a wait
      mwait(1'b0, FRZ);
      mwait(1'b0, FRZ);
      do_rst();
      nop();
      // saturation at 7
      for (int i = 0; i < 10; i++)
         step(0, 5'd8, 5'd3, 1'b0, 1, 5'd8, 0, 0, 0, LU);
      nop();
      nop();
      repeat (3) @(posedge clk);
      chk("drain", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic nop_err();
      step(0, 5'd1, 5'd2, 1'b1, 0, 5'd0, 0, 0, 0, FRZ);
   endtask

endmodule
